// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle control sequencer for the MIPS R/I/J datapath. It fetches an
//   instruction over a req/ack memory port into the internal IR. It then walks
//   the shared ALU, register file and memory through IF/ID/EX/MEM/WB.
//
//   Optional feature macro: INSTR_CNT_EN (adds the 32-bit retired-instruction
//   counter output instr_cnt).
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     mem_rdata, mem_ack  memory read data / access acknowledge
//     zf                  ALU zero flag (valid in EX)
//     Mem_Read, Mem_Write memory requests, held until acknowledged
//     mem_addr_s          address select: 0 = PC, 1 = ALU result
//     IR_Write, PC_Write  IR load strobe, PC load enable
//     PC_s                PC source: 00 = PC+4, 10 = branch, 11 = jump
//     Write_Reg, w_r_s    reg-file write enable / write-register select
//     wr_data_s           write-data select: 00 = ALU, 01 = mem, 10 = PC+4
//     rt_imm_s, imm_s, OP ALU B select, immediate sign-extend, ALU operation
//     rs, rt, rd, imm_offset, addressb   IR fields
//     state, illegal      current state, undecodable-instruction pulse
//
//   state | meaning
//   IDLE  | post-reset, one cycle before the first fetch
//   IF    | fetch request; on ack load IR and advance PC
//   ID    | decode IR; illegal instructions retire here
//   EX    | ALU operation; branches and jumps resolve here
//   MEM   | load/store access at the ALU-computed address
//   WB    | register-file write
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        zf,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic        mem_addr_s,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic [1:0]  PC_s,
    output logic        Write_Reg,
    output logic [1:0]  w_r_s,
    output logic [1:0]  wr_data_s,
    output logic        rt_imm_s,
    output logic        imm_s,
    output logic [2:0]  OP,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm_offset,
    output logic [25:0] addressb,
    output logic [2:0]  state,
    output logic        illegal
`ifdef INSTR_CNT_EN
    ,
    output logic [31:0] instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2,
        S_EX   = 3'd3, S_MEM = 3'd4, S_WB = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILL
    } cls_t;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    cls_t        cls;
    logic [2:0]  alu_op;
    logic        use_imm;
    logic        sext;

    // Instruction class and ALU controls decoded from the IR
    always_comb begin
        cls     = C_ILL;
        alu_op  = 3'b000;
        use_imm = 1'b0;
        sext    = 1'b0;
        unique case (ir_q[31:26])
            6'b000000: begin
                cls = C_R;
                unique case (ir_q[5:0])
                    6'b100000: alu_op = 3'b100;
                    6'b100010: alu_op = 3'b101;
                    6'b100100: alu_op = 3'b000;
                    6'b100101: alu_op = 3'b001;
                    6'b100110: alu_op = 3'b010;
                    6'b100111: alu_op = 3'b011;
                    6'b101011: alu_op = 3'b110;
                    6'b000100: alu_op = 3'b111;
                    default:   cls    = C_ILL;
                endcase
            end
            6'b001000: begin cls = C_I; alu_op = 3'b100; use_imm = 1'b1; sext = 1'b1; end
            6'b001100: begin cls = C_I; alu_op = 3'b000; use_imm = 1'b1; end
            6'b001101: begin cls = C_I; alu_op = 3'b001; use_imm = 1'b1; end
            6'b001110: begin cls = C_I; alu_op = 3'b010; use_imm = 1'b1; end
            6'b001011: begin cls = C_I; alu_op = 3'b110; use_imm = 1'b1; end
            6'b100011: begin cls = C_LW; alu_op = 3'b100; use_imm = 1'b1; sext = 1'b1; end
            6'b101011: begin cls = C_SW; alu_op = 3'b100; use_imm = 1'b1; sext = 1'b1; end
            6'b000100: begin cls = C_BEQ; alu_op = 3'b101; end
            6'b000101: begin cls = C_BNE; alu_op = 3'b101; end
            6'b000010: cls = C_J;
            6'b000011: cls = C_JAL;
            default:   cls = C_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    state_d = S_ID;
                end
            end
            S_ID:  state_d = (cls == C_ILL) ? S_IF : S_EX;
            S_EX: begin
                unique case (cls)
                    C_R, C_I:   state_d = S_WB;
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (mem_ack) state_d = (cls == C_LW) ? S_WB : S_IF;
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        mem_addr_s = 1'b0;
        IR_Write   = 1'b0;
        PC_Write   = 1'b0;
        PC_s       = 2'b00;
        Write_Reg  = 1'b0;
        w_r_s      = 2'b00;
        wr_data_s  = 2'b00;
        rt_imm_s   = 1'b0;
        imm_s      = 1'b0;
        OP         = 3'b000;
        illegal    = 1'b0;
        unique case (state_q)
            S_IF: begin
                Mem_Read = 1'b1;
                if (mem_ack) begin
                    IR_Write = 1'b1;
                    PC_Write = 1'b1;
                end
            end
            S_ID: illegal = (cls == C_ILL);
            S_EX: begin
                OP       = alu_op;
                rt_imm_s = use_imm;
                imm_s    = sext;
                unique case (cls)
                    C_BEQ: begin PC_Write = zf;  PC_s = 2'b10; end
                    C_BNE: begin PC_Write = !zf; PC_s = 2'b10; end
                    C_J:   begin PC_Write = 1'b1; PC_s = 2'b11; end
                    C_JAL: begin
                        PC_Write  = 1'b1;
                        PC_s      = 2'b11;
                        Write_Reg = 1'b1;
                        w_r_s     = 2'b10;
                        wr_data_s = 2'b10;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_addr_s = 1'b1;
                OP         = alu_op;
                rt_imm_s   = use_imm;
                imm_s      = sext;
                Mem_Read   = (cls == C_LW);
                Mem_Write  = (cls == C_SW);
            end
            S_WB: begin
                Write_Reg = 1'b1;
                w_r_s     = (cls == C_R)  ? 2'b00 : 2'b01;
                wr_data_s = (cls == C_LW) ? 2'b01 : 2'b00;
            end
            default: ;
        endcase
    end

    assign rs         = ir_q[25:21];
    assign rt         = ir_q[20:16];
    assign rd         = ir_q[15:11];
    assign imm_offset = ir_q[15:0];
    assign addressb   = ir_q[25:0];
    assign state      = state_q;

`ifdef INSTR_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        retire;

    // Retirement points: every WB exit, branch/jump EX exit, sw MEM exit, illegal ID exit
    always_comb begin
        unique case (state_q)
            S_ID:    retire = (cls == C_ILL);
            S_EX:    retire = (cls == C_BEQ) || (cls == C_BNE) || (cls == C_J) || (cls == C_JAL);
            S_MEM:   retire = mem_ack && (cls == C_SW);
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
        cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        zf;
    logic        Mem_Read, Mem_Write, mem_addr_s, IR_Write, PC_Write;
    logic [1:0]  PC_s, w_r_s, wr_data_s;
    logic        Write_Reg, rt_imm_s, imm_s, illegal;
    logic [2:0]  OP, state;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm_offset;
    logic [25:0] addressb;
`ifdef INSTR_CNT_EN
    logic [31:0] instr_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .zf         (zf),
        .Mem_Read   (Mem_Read),
        .Mem_Write  (Mem_Write),
        .mem_addr_s (mem_addr_s),
        .IR_Write   (IR_Write),
        .PC_Write   (PC_Write),
        .PC_s       (PC_s),
        .Write_Reg  (Write_Reg),
        .w_r_s      (w_r_s),
        .wr_data_s  (wr_data_s),
        .rt_imm_s   (rt_imm_s),
        .imm_s      (imm_s),
        .OP         (OP),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm_offset (imm_offset),
        .addressb   (addressb),
        .state      (state),
        .illegal    (illegal)
`ifdef INSTR_CNT_EN
        ,
        .instr_cnt  (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in IF: present the instruction with an immediate ack, then move to ID
    task automatic fetch(input logic [31:0] instr);
        mem_rdata = instr;
        mem_ack   = 1'b1;
        #1;
        check("if_state", 32'(state), 32'd1);
        check("if_irw", 32'(IR_Write), 32'd1);
        step();
        mem_ack = 1'b0;
        #1;
    endtask

    task automatic run_branch(input string tag, input logic [31:0] instr, input logic z,
                              input logic exp_pcw);
        fetch(instr);
        check({tag, "_id"}, 32'(state), 32'd2);
        step();
        zf = z;
        #1;
        check({tag, "_ex_state"}, 32'(state), 32'd3);
        check({tag, "_pcw"}, 32'(PC_Write), 32'(exp_pcw));
        check({tag, "_pcs"}, 32'(PC_s), 32'd2);
        check({tag, "_op"}, 32'(OP), 32'd5);
        step();
        zf = 1'b0;
        check({tag, "_back_if"}, 32'(state), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        zf        = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mrd", 32'(Mem_Read), 32'd0);
        check("rst_addrb", 32'(addressb), 32'd0);
        check("rst_pcw", 32'(PC_Write), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("idle_state", 32'(state), 32'd0);
        check("idle_mrd", 32'(Mem_Read), 32'd0);
        step();
        check("first_if", 32'(state), 32'd1);
        check("first_mrd", 32'(Mem_Read), 32'd1);
        check("first_addr_s", 32'(mem_addr_s), 32'd0);

        // add $3,$1,$2 with a one-cycle stall before the ack
        step();
        check("if_stall", 32'(state), 32'd1);
        check("if_stall_irw", 32'(IR_Write), 32'd0);
        mem_rdata = 32'h0022_1820;
        mem_ack   = 1'b1;
        #1;
        check("add_pcw", 32'(PC_Write), 32'd1);
        check("add_pcs", 32'(PC_s), 32'd0);
        step();
        mem_ack = 1'b0;
        check("add_id", 32'(state), 32'd2);
        check("add_rs", 32'(rs), 32'd1);
        check("add_rt", 32'(rt), 32'd2);
        check("add_rd", 32'(rd), 32'd3);
        check("add_ill", 32'(illegal), 32'd0);
        step();
        check("add_ex", 32'(state), 32'd3);
        check("add_op", 32'(OP), 32'd4);
        check("add_rtimm", 32'(rt_imm_s), 32'd0);
        check("add_wr_ex", 32'(Write_Reg), 32'd0);
        step();
        check("add_wb", 32'(state), 32'd5);
        check("add_wreg", 32'(Write_Reg), 32'd1);
        check("add_wrs", 32'(w_r_s), 32'd0);
        check("add_wds", 32'(wr_data_s), 32'd0);
        step();
        check("add_next_if", 32'(state), 32'd1);

        // lw $3,4($2) with ack withheld for two MEM cycles
        fetch(32'h8C43_0004);
        step();
        check("lw_ex_op", 32'(OP), 32'd4);
        check("lw_ex_imm", 32'(imm_s), 32'd1);
        step();
        mem_ack = 1'b0;
        #1;
        check("lw_mem1", 32'(state), 32'd4);
        check("lw_mem1_mrd", 32'(Mem_Read), 32'd1);
        check("lw_mem1_mwr", 32'(Mem_Write), 32'd0);
        check("lw_mem1_as", 32'(mem_addr_s), 32'd1);
        check("lw_mem_op", 32'(OP), 32'd4);
        step();
        check("lw_mem2", 32'(state), 32'd4);
        check("lw_mem2_mrd", 32'(Mem_Read), 32'd1);
        step();
        mem_ack = 1'b1;
        #1;
        check("lw_mem3", 32'(state), 32'd4);
        check("lw_mem3_mrd", 32'(Mem_Read), 32'd1);
        step();
        mem_ack = 1'b0;
        #1;
        check("lw_wb", 32'(state), 32'd5);
        check("lw_wrs", 32'(w_r_s), 32'd1);
        check("lw_wds", 32'(wr_data_s), 32'd1);
        check("lw_imm", 32'(imm_offset), 32'h0004);
        step();
        check("lw_next_if", 32'(state), 32'd1);

        run_branch("beq_z1", 32'h1022_0003, 1'b1, 1'b1);
        run_branch("beq_z0", 32'h1022_0003, 1'b0, 1'b0);
        run_branch("bne_z1", 32'h1422_0003, 1'b1, 1'b0);
        run_branch("bne_z0", 32'h1422_0003, 1'b0, 1'b1);

        // jal
        fetch(32'h0C00_0010);
        step();
        check("jal_ex", 32'(state), 32'd3);
        check("jal_pcs", 32'(PC_s), 32'd3);
        check("jal_pcw", 32'(PC_Write), 32'd1);
        check("jal_wreg", 32'(Write_Reg), 32'd1);
        check("jal_wrs", 32'(w_r_s), 32'd2);
        check("jal_wds", 32'(wr_data_s), 32'd2);
        check("jal_addrb", 32'(addressb), 32'h0000010);
        step();
        check("jal_next_if", 32'(state), 32'd1);

        // ori: zero-extended immediate, WB to rt
        fetch(32'h3443_00FF);
        step();
        check("ori_op", 32'(OP), 32'd1);
        check("ori_rtimm", 32'(rt_imm_s), 32'd1);
        check("ori_imms", 32'(imm_s), 32'd0);
        step();
        check("ori_wrs", 32'(w_r_s), 32'd1);
        step();

        // undecodable opcode 0x3F
        fetch(32'hFC00_0000);
        check("ill_pulse", 32'(illegal), 32'd1);
        step();
        check("ill_back_if", 32'(state), 32'd1);
        check("ill_gone", 32'(illegal), 32'd0);

        // R-type with an unknown funct
        fetch(32'h0022_1801);
        check("ill_funct", 32'(illegal), 32'd1);
        step();

        // sw completing with zero wait
        fetch(32'hAC43_0008);
        step();
        step();
        mem_ack = 1'b1;
        #1;
        check("sw_mem", 32'(state), 32'd4);
        check("sw_mwr", 32'(Mem_Write), 32'd1);
        check("sw_mrd", 32'(Mem_Read), 32'd0);
        step();
        mem_ack = 1'b0;
        check("sw_next_if", 32'(state), 32'd1);

        // sw interrupted by reset in MEM
        fetch(32'hAC43_0008);
        step();
        step();
        check("sw2_mwr", 32'(Mem_Write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_state", 32'(state), 32'd0);
        check("async_mwr", 32'(Mem_Write), 32'd0);
        check("async_ir", 32'(imm_offset), 32'd0);
        check("async_rt", 32'(rt), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rel_idle", 32'(state), 32'd0);
        step();
        check("rel_if_mrd", 32'(Mem_Read), 32'd1);

`ifdef INSTR_CNT_EN
        check("cnt_rst", instr_cnt, 32'd0);
        fetch(32'h0022_1820);   // add: ID, EX, WB
        step(); step(); step();
        fetch(32'h8C43_0004);   // lw: ID, EX, MEM, WB
        step(); step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        step();
        fetch(32'h1022_0003);   // beq: ID, EX
        step(); step();
        fetch(32'hAC43_0008);   // sw: ID, EX, MEM
        step(); step();
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        fetch(32'hFC00_0000);   // illegal: ID
        step();
        check("cnt_state", 32'(state), 32'd1);
        check("cnt_five", instr_cnt, 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control sequencer for the MIPS R/I/J datapath. It fetches each instruction over a request/acknowledge memory port and latches it into an internal instruction register (IR). It then steps the shared ALU, register file and memory through the IF/ID/EX/MEM/WB phases, driving the same select and enable signals the single-cycle decoder drives, but asserting each only in its phase. It sits between the unified instruction/data memory and the existing datapath muxes, PC register and register file.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mem_rdata  in  32  memory read data; captured into IR on a fetch acknowledge
- mem_ack  in  1  memory acknowledge; sampled on the rising edge; completes the pending access
- zf  in  1  ALU zero flag; valid in EX
- Mem_Read  out  1  memory read request, held until acknowledged
- Mem_Write  out  1  memory write request, held until acknowledged
- mem_addr_s  out  1  address select: 0 = PC, 1 = ALU result
- IR_Write  out  1  IR load strobe
- PC_Write  out  1  PC load enable
- PC_s  out  2  PC source: 00 = PC+4, 10 = branch target, 11 = jump target
- Write_Reg  out  1  register-file write enable
- w_r_s  out  2  write-register select: 00 = rd, 01 = rt, 10 = r31
- wr_data_s  out  2  write-data select: 00 = ALU, 01 = memory, 10 = PC+4
- rt_imm_s  out  1  ALU B select: 0 = rt, 1 = immediate
- imm_s  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- OP  out  3  ALU operation
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- imm_offset  out  16  IR[15:0]
- addressb  out  26  IR[25:0]
- state  out  3  current state encoding
- illegal  out  1  one-cycle pulse on an undecodable instruction

## Operation
- States and encodings: IDLE = 0, IF = 1, ID = 2, EX = 3, MEM = 4, WB = 5.
- Reset: state = IDLE and IR = 0. All outputs are 0, including the field outputs.
- IDLE: go to IF unconditionally.
- IF: Mem_Read = 1 and mem_addr_s = 0.
  - On mem_ack: IR_Write = 1, PC_Write = 1 with PC_s = 00, IR <= mem_rdata, go to ID.
  - Without mem_ack: stay in IF.
- ID: decode IR.
  - Undecodable opcode or R-type funct: illegal = 1, go to IF. The instruction retires as a NOP; PC has already advanced.
  - Otherwise go to EX.
- ALU OP encoding:
  - R-type by funct: add 100000 -> 100, sub 100010 -> 101, and 100100 -> 000, or 100101 -> 001, xor 100110 -> 010, nor 100111 -> 011, sltu 101011 -> 110, sllv 000100 -> 111.
  - I-type by opcode: addi 001000 -> 100 with imm_s = 1; andi 001100, ori 001101, xori 001110, sltiu 001011 -> 000, 001, 010, 110 with imm_s = 0.
  - lw 100011 and sw 101011 use OP = 100 with imm_s = 1.
  - beq 000100 and bne 000101 use OP = 101 with rt_imm_s = 0.
- EX: OP, rt_imm_s and imm_s are driven per the table above. Next state by instruction class:
  - R-type and I-type ALU: go to WB.
  - lw and sw: go to MEM.
  - beq: PC_Write = zf, PC_s = 10, go to IF.
  - bne: PC_Write = !zf, PC_s = 10, go to IF.
  - j 000010: PC_Write = 1, PC_s = 11, go to IF.
  - jal 000011: same as j, plus Write_Reg = 1, w_r_s = 10, wr_data_s = 10.
- MEM: mem_addr_s = 1; OP, rt_imm_s and imm_s hold their EX values.
  - lw: Mem_Read = 1 until mem_ack, then go to WB.
  - sw: Mem_Write = 1 until mem_ack, then go to IF.
- WB: Write_Reg = 1, then go to IF.
  - R-type: w_r_s = 00, wr_data_s = 00.
  - I-type ALU: w_r_s = 01, wr_data_s = 00.
  - lw: w_r_s = 01, wr_data_s = 01.
- Any control output not listed for a state is 0 in that state.
- The field outputs always reflect IR.

## Timing
- Control outputs are combinational decodes of the state register and IR; state and IR are registered.
- Latency with zero-wait memory (mem_ack = 1 in the request's first cycle):
  - R-type and I-type ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branches and jumps: 3 cycles.
- Each cycle without mem_ack in IF or MEM adds one cycle.
- Mem_Read and Mem_Write are never asserted together.
- Request signals stay stable until the acknowledging edge.
- mem_ack is ignored in ID, EX, WB and IDLE.
- Write_Reg is asserted for exactly one cycle per writing instruction.
- PC_Write is asserted at most once in IF and at most once in EX per instruction.
- An rst_n assertion in any state forces IDLE, IR = 0 and all outputs 0 immediately, without waiting for a clock edge; a pending memory request is dropped.
- After reset deasserts, the first Mem_Read appears one cycle later, in IF.

## Configuration
- INSTR_CNT_EN defined:
  - Adds output instr_cnt (32 bits, reset 0).
  - The counter increments on each retirement: leaving WB; leaving EX for branches and jumps; leaving MEM for sw; leaving ID on illegal.
  - It wraps from 0xFFFFFFFF to 0.
- INSTR_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- add, mem_rdata = 0x00221820, zero-wait memory -> states IF, ID, EX, WB; OP = 100; in WB, Write_Reg = 1 with w_r_s = 00 and rd = 3; the next IF starts on cycle 5.
- lw 0x8C430004, with mem_ack withheld for 2 cycles in MEM -> MEM lasts 3 cycles with Mem_Read = 1 and mem_addr_s = 1; then WB with w_r_s = 01, wr_data_s = 01, imm_offset = 0x0004.
- beq 0x10220003: with zf = 1, EX gives PC_Write = 1 and PC_s = 10; with zf = 0, EX gives PC_Write = 0. bne gives the opposite result in each case; both take 3 cycles.
- jal 0x0C000010 -> EX gives PC_s = 11, PC_Write = 1, Write_Reg = 1, w_r_s = 10, wr_data_s = 10, addressb = 0x0000010.
- Opcode 0x3F, then rst_n pulsed low during MEM of an sw -> illegal pulses in ID; on reset, state = 0, Mem_Write = 0 asynchronously, and IR reads back 0.
- With INSTR_CNT_EN defined, run 5 mixed instructions -> instr_cnt = 5.
